sprite_draw: RTL
================

Name: sprite_draw

Overview:
- Reader/consumer side of the 16x16 sprite colour ROMs (e.g. player_rom). It sits between the VGA sync/pixel generator and the pixel mux.
- Converts the current scan pixel (x, y) and a frame-latched sprite position into ROM row/col addresses.
- Absorbs the ROM's one-cycle registered-address latency and produces a pipelined pixel output, with transparency keying.
- Counts the opaque pixels drawn per frame, for coarse collision logic.

Parameters:
- X_W, 10, width of the x coordinate and position.
- Y_W, 10, width of the y coordinate and position.
- TRANSPARENT, 8'hBB, colour value treated as see-through.

Ports:
- clk  in  1  system/pixel clock.
- reset_n  in  1  asynchronous, active-low reset.
- video_on  in  1  high inside the visible area.
- x  in  X_W  current pixel column.
- y  in  Y_W  current pixel row.
- frame_tick  in  1  one-cycle pulse at start of vblank.
- pos_valid  in  1  new sprite position offered.
- pos_ready  out  1  block can accept a position.
- pos_x  in  X_W  requested sprite left edge.
- pos_y  in  Y_W  requested sprite top edge.
- row  out  4  ROM row address.
- col  out  4  ROM column address.
- color_data  in  8  ROM output; valid one cycle after row/col.
- pix_valid  out  1  opaque sprite pixel present on pix_color.
- pix_color  out  8  sprite colour; 0 when pix_valid=0.
- opaque_count  out  9  opaque pixels drawn in the previous frame.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - act_x=act_y=0, pend=0, in_box_d1=0, pix_valid=0, pix_color=0, opaque_count=0, run_cnt=0.
  - pos_ready=1 after reset.
- Position handshake:
  - pos_ready = ~pend.
  - pos_valid&&pos_ready: capture pos_x/pos_y into pend_x/pend_y; pend<=1.
  - frame_tick&&pend: act<=pend values; pend<=0.
  - Transfer and frame_tick in the same cycle: capture happens; the new position applies at the NEXT frame_tick.
  - pend=1: further pos_valid is ignored (not accepted) until the next frame_tick.
- Stage 0 (combinational):
  - in_box = video_on && x>=act_x && x<act_x+16 && y>=act_y && y<act_y+16.
  - Compare at X_W+1 / Y_W+1 bits so act+16 never wraps. A sprite at x=1020 draws columns 1020..1023 only; no column 0 ghost.
  - row = (y-act_y)[3:0] and col = (x-act_x)[3:0] when in_box, else 0.
- Stage 1: in_box_d1 <= in_box; color_data arrives this cycle.
- Stage 2 (registered):
  - opq = in_box_d1 && color_data!=TRANSPARENT.
  - pix_valid <= opq; pix_color <= opq ? color_data : 0.
- Latency: 2 clk from x/y to pix_valid/pix_color. There is no stall; one pixel per clock.
- Counter:
  - run_cnt increments on each cycle with registered pix_valid=1, saturating at 256.
  - On frame_tick: opaque_count <= run_cnt (excluding any same-cycle pixel); run_cnt <= (pix_valid ? 1 : 0).
- A position change affects only pixels whose stage-0 evaluation is after the frame_tick edge.
- Reset mid-frame clears the pipeline immediately; there is no partial-frame count.

Optional Feature:
- Macro: SPRITE_MIRROR_EN.
- When defined:
  - Adds input mirror_in (1 bit), captured into pend with pos_x/pos_y under the same handshake and applied at frame_tick.
  - When the applied mirror bit is 1, col = 15-(x-act_x)[3:0] (horizontal flip); row is unchanged.
- When undefined: no mirror_in port, and col is never flipped.

Test Plan:
- Reset: assert reset_n=0 mid-frame -> all outputs 0 asynchronously, pos_ready=1, opaque_count=0.
- Handshake:
  - pos_valid with (100,50), then pos_valid with (200,60) before frame_tick -> pos_ready=0 and the second request is ignored.
  - After frame_tick, sprite at (100,50) and pos_ready=1.
- Addressing:
  - Scan x=100..115, y=57 -> row=7, col=0..15 in the same cycle.
  - pix_valid follows 2 cycles later exactly where the ROM colour is not 8'hBB.
  - The 8'hBB pixels give pix_valid=0, pix_color=0.
- Edge: position (1020,0), scan x=1016..1023 and x=0..3 -> row/col driven only for x=1020..1023; nothing at x=0..3.
- Count: full frame with the player sprite fully visible -> opaque_count=101 after the next frame_tick.
  - With frame_tick coinciding with an opaque pixel: opaque_count=100, and the next frame starts at 1.
- SPRITE_MIRROR_EN: mirror_in=1 applied, scan row 0 -> col sequence 15..0.

Source files
------------

// File: rtl/sprite_draw.sv
// Sprite reader: maps scan (x, y) to 16x16 ROM row/col, keys out the transparent colour and
// counts opaque pixels per frame. Define SPRITE_MIRROR_EN to add a horizontal-flip input.
module sprite_draw #(
  parameter int unsigned X_W         = 10,
  parameter int unsigned Y_W         = 10,
  parameter logic [7:0]  TRANSPARENT = 8'hBB
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           video_on,
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  input  logic           frame_tick,
  input  logic           pos_valid,
  output logic           pos_ready,
  input  logic [X_W-1:0] pos_x,
  input  logic [Y_W-1:0] pos_y,
`ifdef SPRITE_MIRROR_EN
  input  logic           mirror_in,
`endif
  output logic [3:0]     row,
  output logic [3:0]     col,
  input  logic [7:0]     color_data,
  output logic           pix_valid,
  output logic [7:0]     pix_color,
  output logic [8:0]     opaque_count
);

  logic [X_W-1:0] act_x_q, act_x_d, pend_x_q, pend_x_d;
  logic [Y_W-1:0] act_y_q, act_y_d, pend_y_q, pend_y_d;
  logic           pend_q, pend_d;
  logic           mir_act;
`ifdef SPRITE_MIRROR_EN
  logic           act_mir_q, act_mir_d, pend_mir_q, pend_mir_d;
`endif

  logic           in_box;
  logic           in_box_d1_q;
  logic           opq;
  logic           pix_valid_q, pix_valid_d;
  logic [7:0]     pix_color_q, pix_color_d;
  logic [8:0]     run_cnt_q, run_cnt_d;
  logic [8:0]     opaque_q, opaque_d;

  assign pos_ready = ~pend_q;

  // Position handshake: a captured position waits in pend until the next frame_tick.
  always_comb begin
    act_x_d  = act_x_q;
    act_y_d  = act_y_q;
    pend_x_d = pend_x_q;
    pend_y_d = pend_y_q;
    pend_d   = pend_q;
`ifdef SPRITE_MIRROR_EN
    act_mir_d  = act_mir_q;
    pend_mir_d = pend_mir_q;
`endif
    if (frame_tick && pend_q) begin
      act_x_d = pend_x_q;
      act_y_d = pend_y_q;
`ifdef SPRITE_MIRROR_EN
      act_mir_d = pend_mir_q;
`endif
      pend_d  = 1'b0;
    end
    if (pos_valid && pos_ready) begin
      pend_x_d = pos_x;
      pend_y_d = pos_y;
`ifdef SPRITE_MIRROR_EN
      pend_mir_d = mirror_in;
`endif
      pend_d   = 1'b1;
    end
  end

`ifdef SPRITE_MIRROR_EN
  assign mir_act = act_mir_q;
`else
  assign mir_act = 1'b0;
`endif

  // Stage 0: bounds compared one bit wider so act + 16 never wraps past the screen edge.
  logic [X_W:0] x_ext, ax_lo, ax_hi;
  logic [Y_W:0] y_ext, ay_lo, ay_hi;
  logic [3:0]   col_raw;

  assign x_ext = {1'b0, x};
  assign ax_lo = {1'b0, act_x_q};
  assign ax_hi = ax_lo + (X_W+1)'(16);
  assign y_ext = {1'b0, y};
  assign ay_lo = {1'b0, act_y_q};
  assign ay_hi = ay_lo + (Y_W+1)'(16);

  assign in_box = video_on && (x_ext >= ax_lo) && (x_ext < ax_hi) &&
                  (y_ext >= ay_lo) && (y_ext < ay_hi);

  assign col_raw = x[3:0] - act_x_q[3:0];

  always_comb begin
    row = 4'd0;
    col = 4'd0;
    if (in_box) begin
      row = y[3:0] - act_y_q[3:0];
      col = mir_act ? ~col_raw : col_raw;
    end
  end

  // Stage 2: colour arrives alongside in_box_d1; register the keyed pixel.
  assign opq         = in_box_d1_q && (color_data != TRANSPARENT);
  assign pix_valid_d = opq;
  assign pix_color_d = opq ? color_data : 8'h00;

  // Pixel registered in the frame_tick cycle belongs to the new frame.
  always_comb begin
    run_cnt_d = run_cnt_q;
    opaque_d  = opaque_q;
    if (frame_tick) begin
      opaque_d  = run_cnt_q;
      run_cnt_d = {8'd0, pix_valid_q};
    end else if (pix_valid_q && (run_cnt_q != 9'd256)) begin
      run_cnt_d = run_cnt_q + 9'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act_x_q     <= '0;
      act_y_q     <= '0;
      pend_x_q    <= '0;
      pend_y_q    <= '0;
      pend_q      <= 1'b0;
      in_box_d1_q <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_color_q <= 8'h00;
      run_cnt_q   <= 9'd0;
      opaque_q    <= 9'd0;
    end else begin
      act_x_q     <= act_x_d;
      act_y_q     <= act_y_d;
      pend_x_q    <= pend_x_d;
      pend_y_q    <= pend_y_d;
      pend_q      <= pend_d;
      in_box_d1_q <= in_box;
      pix_valid_q <= pix_valid_d;
      pix_color_q <= pix_color_d;
      run_cnt_q   <= run_cnt_d;
      opaque_q    <= opaque_d;
    end
  end

`ifdef SPRITE_MIRROR_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act_mir_q  <= 1'b0;
      pend_mir_q <= 1'b0;
    end else begin
      act_mir_q  <= act_mir_d;
      pend_mir_q <= pend_mir_d;
    end
  end
`endif

  assign pix_valid    = pix_valid_q;
  assign pix_color    = pix_color_q;
  assign opaque_count = opaque_q;

endmodule
